// File: rtl/pos_counter_filt_if.sv
// pos_counter_filt_if
//   Groups the step/dir pins, the register-file controls and the position
//   status of one pos_counter_filt instance.
//   master : pin/register side, drives pins and controls, reads status.
//   slave  : the counter itself.
//   Signals: step, dir (raw pins); invert_dir, edge_mode, multiplier, sat_en,
//   load, load_value, capture, clear_flags (controls); count, step_pulse,
//   dir_eff, overflow, captured, capture_valid (status).
interface pos_counter_filt_if #(
    parameter int WIDTH  = 32,
    parameter int MULT_W = 8
);
    logic              step;
    logic              dir;
    logic              invert_dir;
    logic [1:0]        edge_mode;
    logic [MULT_W-1:0] multiplier;
    logic              sat_en;
    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic              capture;
    logic              clear_flags;
    logic [WIDTH-1:0]  count;
    logic              step_pulse;
    logic              dir_eff;
    logic              overflow;
    logic [WIDTH-1:0]  captured;
    logic              capture_valid;

    modport master (
        output step, dir, invert_dir, edge_mode, multiplier, sat_en,
               load, load_value, capture, clear_flags,
        input  count, step_pulse, dir_eff, overflow, captured, capture_valid
    );

    modport slave (
        input  step, dir, invert_dir, edge_mode, multiplier, sat_en,
               load, load_value, capture, clear_flags,
        output count, step_pulse, dir_eff, overflow, captured, capture_valid
    );
endinterface

// File: rtl/pos_counter_filt.sv
// pos_counter_filt
//   Step/dir position counter for a motion axis. The raw step and dir pins
//   are synchronised (2 flops) and glitch-filtered; accepted step edges of the
//   selected polarity move the signed count by the multiplier, up or down
//   according to the filtered direction. Wrap or saturate on signed overflow,
//   with a sticky overflow flag. Also offers preload and position capture.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : pos_counter_filt_if.slave (pins, controls, status)
module pos_counter_filt #(
    parameter int WIDTH      = 32,
    parameter int MULT_W     = 8,
    parameter int FILTER_LEN = 2
) (
    input  logic                clk,
    input  logic                reset,
    pos_counter_filt_if.slave   bus
);
    localparam logic [7:0]       FCNT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] CNT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    // Index 0 = step, index 1 = dir.
    logic [1:0] pin_raw;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] filt;
    logic [7:0] fcnt [2];
    logic [1:0] accept;

    logic             step_hit;
    logic             dir_up;
    logic [WIDTH:0]   mult_ext;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] step_val;

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] captured_r;
    logic             step_pulse_r;
    logic             overflow_r;
    logic             capture_valid_r;

    assign pin_raw = {bus.dir, bus.step};

    // Accept fires on the clock where the synchronised level has disagreed
    // with the filtered level for FILTER_LEN consecutive clocks.
    always_comb begin
        accept = 2'b00;
        for (int i = 0; i < 2; i++) begin
            accept[i] = (s2[i] != filt[i]) && (fcnt[i] == FCNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 2'b00;
            s2   <= 2'b00;
            filt <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= 8'd0;
            end
        end else begin
            s1 <= pin_raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= 8'd0;
                end else if (accept[i]) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= 8'd0;
                end else begin
                    fcnt[i] <= fcnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        step_hit = 1'b0;
        if (accept[0]) begin
            case (bus.edge_mode)
                2'b00:   step_hit = s2[0];
                2'b01:   step_hit = ~s2[0];
                2'b10:   step_hit = 1'b1;
                default: step_hit = 1'b0;
            endcase
        end
    end

    // Direction comes from the filtered level held before this clock, so a
    // dir accept landing together with a step accept does not steer it.
    assign dir_up   = filt[1] ^ bus.invert_dir;
    assign mult_ext = {{(WIDTH + 1 - MULT_W){1'b0}}, bus.multiplier};
    assign cnt_ext  = {count_r[WIDTH-1], count_r};
    assign sum      = dir_up ? (cnt_ext + mult_ext) : (cnt_ext - mult_ext);
    // The extra top bit keeps the true sign; disagreement with bit WIDTH-1
    // means the result does not fit in WIDTH bits.
    assign sum_ovf  = sum[WIDTH] ^ sum[WIDTH-1];

    always_comb begin
        step_val = sum[WIDTH-1:0];
        if (sum_ovf && bus.sat_en) begin
            step_val = sum[WIDTH] ? CNT_MIN : CNT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_r         <= '0;
            captured_r      <= '0;
            step_pulse_r    <= 1'b0;
            overflow_r      <= 1'b0;
            capture_valid_r <= 1'b0;
        end else begin
            step_pulse_r <= 1'b0;
            if (bus.load) begin
                count_r <= bus.load_value;
            end else if (step_hit) begin
                count_r      <= step_val;
                step_pulse_r <= 1'b1;
            end

            if (step_hit && !bus.load && sum_ovf) begin
                overflow_r <= 1'b1;
            end else if (bus.clear_flags) begin
                overflow_r <= 1'b0;
            end

            capture_valid_r <= bus.capture;
            if (bus.capture) begin
                captured_r <= count_r;
            end
        end
    end

    assign bus.count         = count_r;
    assign bus.step_pulse    = step_pulse_r;
    assign bus.dir_eff       = dir_up;
    assign bus.overflow      = overflow_r;
    assign bus.captured      = captured_r;
    assign bus.capture_valid = capture_valid_r;
endmodule
